// File: rtl/ultrasonic_ranger_if.sv
// Pin bundle between the ranger and its three HC-SR04-class sensors plus the result outputs.
// upd is a one-cycle strobe coinciding with a dist_* write; valid is a level that stays high once set.
interface ultrasonic_ranger_if;
   logic       echo_m;
   logic       echo_r;
   logic       echo_l;
   logic       trig_m;
   logic       trig_r;
   logic       trig_l;
   logic [7:0] dist_m;
   logic [7:0] dist_r;
   logic [7:0] dist_l;
   logic [1:0] sel;
   logic       upd;
   logic       valid;
   logic [1:0] dbg_state;

   modport master (
      input  echo_m, echo_r, echo_l,
      output trig_m, trig_r, trig_l,
      output dist_m, dist_r, dist_l,
      output sel, upd, valid, dbg_state
   );

   modport slave (
      output echo_m, echo_r, echo_l,
      input  trig_m, trig_r, trig_l,
      input  dist_m, dist_r, dist_l,
      input  sel, upd, valid, dbg_state
   );
endinterface

// File: rtl/ultrasonic_ranger.sv
// Round-robin trigger/echo timer for three ultrasonic sensors producing 8-bit cm distances.
// Define RANGER_TIMEOUT_HOLD_EN to keep the previous distance on timeout instead of writing 255.
module ultrasonic_ranger #(
   parameter int TRIG_CYC = 500,
   parameter int CM_CYC   = 2900,
   parameter int RISE_TO  = 1_500_000,
   parameter int ECHO_TO  = 1_500_000,
   parameter int GAP_CYC  = 500_000
) (
   input logic clk,
   input logic rst,
   ultrasonic_ranger_if.master bus
);

   typedef enum logic [1:0] {
      S_TRIG      = 2'd0,
      S_WAIT_RISE = 2'd1,
      S_MEASURE   = 2'd2,
      S_GAP       = 2'd3
   } state_t;

   state_t      state_q;
   logic [31:0] cnt_q;
   logic [31:0] sub_q;
   logic [31:0] sub_d;
   logic [7:0]  cm_q;
   logic [7:0]  cm_d;
   logic [1:0]  sel_q;
   logic [2:0]  trig_q;
   logic [7:0]  dist_m_q;
   logic [7:0]  dist_r_q;
   logic [7:0]  dist_l_q;
   logic        upd_q;
   logic        valid_q;
   logic [2:0]  echo_s1_q;
   logic [2:0]  echo_s2_q;

   logic        echo_sel;
   logic [2:0]  sel_onehot;
   logic        wr_en;
   logic        wr_timeout;
   logic        dist_wr;
   logic [7:0]  wr_val;
   logic [31:0] base_sub;
   logic [7:0]  base_cm;

   always_comb begin
      echo_sel   = 1'b0;
      sel_onehot = 3'b000;
      case (sel_q)
         2'd0:    begin echo_sel = echo_s2_q[0]; sel_onehot = 3'b001; end
         2'd1:    begin echo_sel = echo_s2_q[1]; sel_onehot = 3'b010; end
         default: begin echo_sel = echo_s2_q[2]; sel_onehot = 3'b100; end
      endcase
   end

   // The rise cycle seen in WAIT_RISE is the first counted echo-high clock.
   always_comb begin
      base_sub = (state_q == S_WAIT_RISE) ? 32'd0 : sub_q;
      base_cm  = (state_q == S_WAIT_RISE) ? 8'd0  : cm_q;
      if (base_sub == 32'(CM_CYC - 1)) begin
         sub_d = 32'd0;
         cm_d  = (base_cm == 8'd255) ? 8'd255 : base_cm + 8'd1;
      end else begin
         sub_d = base_sub + 32'd1;
         cm_d  = base_cm;
      end
   end

   // Timeouts take priority over the echo level on the cycle the limit is reached.
   always_comb begin
      wr_en      = 1'b0;
      wr_timeout = 1'b0;
      case (state_q)
         S_WAIT_RISE: begin
            if (cnt_q == 32'(RISE_TO)) begin
               wr_en      = 1'b1;
               wr_timeout = 1'b1;
            end
         end
         S_MEASURE: begin
            if (cnt_q == 32'(ECHO_TO)) begin
               wr_en      = 1'b1;
               wr_timeout = 1'b1;
            end else if (!echo_sel) begin
               wr_en = 1'b1;
            end
         end
         default: ;
      endcase
   end

`ifdef RANGER_TIMEOUT_HOLD_EN
   assign dist_wr = wr_en && !wr_timeout;
   assign wr_val  = cm_q;
`else
   assign dist_wr = wr_en;
   assign wr_val  = wr_timeout ? 8'd255 : cm_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_TRIG;
         cnt_q     <= 32'd0;
         sub_q     <= 32'd0;
         cm_q      <= 8'd0;
         sel_q     <= 2'd0;
         trig_q    <= 3'b000;
         dist_m_q  <= 8'd0;
         dist_r_q  <= 8'd0;
         dist_l_q  <= 8'd0;
         upd_q     <= 1'b0;
         valid_q   <= 1'b0;
         echo_s1_q <= 3'b000;
         echo_s2_q <= 3'b000;
      end else begin
         echo_s1_q <= {bus.echo_l, bus.echo_r, bus.echo_m};
         echo_s2_q <= echo_s1_q;
         upd_q     <= wr_en;
         if (dist_wr) begin
            case (sel_q)
               2'd0:    dist_m_q <= wr_val;
               2'd1:    dist_r_q <= wr_val;
               default: dist_l_q <= wr_val;
            endcase
         end
         if (wr_en && sel_q == 2'd2) valid_q <= 1'b1;

         case (state_q)
            S_TRIG: begin
               if (cnt_q == 32'(TRIG_CYC)) begin
                  trig_q  <= 3'b000;
                  cnt_q   <= 32'd0;
                  state_q <= S_WAIT_RISE;
               end else begin
                  trig_q <= sel_onehot;
                  cnt_q  <= cnt_q + 32'd1;
               end
            end
            S_WAIT_RISE: begin
               if (wr_en) begin
                  cnt_q   <= 32'd0;
                  state_q <= S_GAP;
               end else if (echo_sel) begin
                  cnt_q   <= 32'd1;
                  sub_q   <= sub_d;
                  cm_q    <= cm_d;
                  state_q <= S_MEASURE;
               end else begin
                  cnt_q <= cnt_q + 32'd1;
               end
            end
            S_MEASURE: begin
               if (wr_en) begin
                  cnt_q   <= 32'd0;
                  state_q <= S_GAP;
               end else begin
                  cnt_q <= cnt_q + 32'd1;
                  sub_q <= sub_d;
                  cm_q  <= cm_d;
               end
            end
            default: begin
               if (cnt_q == 32'(GAP_CYC)) begin
                  cnt_q   <= 32'd0;
                  sel_q   <= (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
                  state_q <= S_TRIG;
               end else begin
                  cnt_q <= cnt_q + 32'd1;
               end
            end
         endcase
      end
   end

   assign bus.trig_m    = trig_q[0];
   assign bus.trig_r    = trig_q[1];
   assign bus.trig_l    = trig_q[2];
   assign bus.dist_m    = dist_m_q;
   assign bus.dist_r    = dist_r_q;
   assign bus.dist_l    = dist_l_q;
   assign bus.sel       = sel_q;
   assign bus.upd       = upd_q;
   assign bus.valid     = valid_q;
   assign bus.dbg_state = state_q;

endmodule

// File: doc/ultrasonic_ranger.md
# ultrasonic_ranger

Ultrasonic front end for the obstacle-avoidance path. It drives three HC-SR04-class sensors (middle, right, left) in strict round-robin so that no two sensors are ever active at once. For each sensor it generates the trigger pulse, times the echo pulse, and converts the width to centimetres. The results are registered 8-bit distances (`dist_m`, `dist_r`, `dist_l`) that feed the avoidance controller directly.

## Interface
Parameters:
- `TRIG_CYC`, 500: trigger pulse width in clocks (10 µs at 50 MHz).
- `CM_CYC`, 2900: clocks per centimetre of echo width (58 µs/cm at 50 MHz).
- `RISE_TO`, 1_500_000: maximum clocks from trigger end to echo rise.
- `ECHO_TO`, 1_500_000: maximum echo-high clocks.
- `GAP_CYC`, 500_000: idle clocks after each measurement, before the next sensor's trigger.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: synchronous reset, active-high.
- `echo_m`, `echo_r`, `echo_l`, in, 1 each: raw asynchronous echo inputs.
- `trig_m`, `trig_r`, `trig_l`, out, 1 each: registered trigger outputs.
- `dist_m`, `dist_r`, `dist_l`, out, 8 each: distance in cm, 0..255.
- `sel`, out, 2: sensor currently being serviced (0 = m, 1 = r, 2 = l).
- `upd`, out, 1: one-cycle pulse when any `dist_*` register is written.
- `valid`, out, 1: high once all three distances have been written since reset.

## Operation
- Each echo input passes through its own 2-flop synchroniser. All timing below refers to the synchronised echo of the selected sensor. Echoes of non-selected sensors are ignored.
- FSM states:
  - TRIG: drive `trig_<sel>` for `TRIG_CYC` clocks, then go to WAIT_RISE.
  - WAIT_RISE: on echo high, go to MEASURE. After `RISE_TO` clocks with no rise, take the timeout result and go to GAP.
  - MEASURE: count echo-high clocks.
    - On echo low: write the distance, go to GAP.
    - After `ECHO_TO` clocks still high: take the timeout result and go to GAP.
  - GAP: wait `GAP_CYC` clocks. Then advance `sel` (0→1→2→0) and go to TRIG.
- Arithmetic:
  - A sub-counter runs 0..`CM_CYC`-1 while echo is high. Each wrap increments an 8-bit cm counter, which saturates at 255 and never wraps.
  - The result is floor(N/`CM_CYC`) clipped to 255, where N is the echo-high clock count.
- Timeout result (from WAIT_RISE or MEASURE): governed by `RANGER_TIMEOUT_HOLD_EN` (see Configuration).
- Echo already high on entry to WAIT_RISE: this counts as a rise on the first WAIT_RISE cycle.
- Only one `trig_*` is ever high, and only while in TRIG.
- Reset mid-operation:
  - Abort immediately and drop all triggers on the next edge.
  - Clear all counters, `dist_*`, and `valid`.
  - Restart in TRIG with `sel` = 0.

## Timing
- Reset values:
  - `trig_*` = 0, `dist_*` = 0, `sel` = 0, `upd` = 0, `valid` = 0.
  - FSM = TRIG with the trigger counter cleared.
- Trigger timing: `trig_m` rises on the first edge at which `rst` is sampled low and stays high exactly `TRIG_CYC` cycles.
- Echo-to-update latency:
  - 2 cycles of synchroniser delay plus 1 register stage.
  - The `dist_*` write happens 3 cycles after the raw echo falling edge.
  - `upd` is high in the same cycle the new value first appears.
- Timeout write: occurs in the cycle after the timeout count is reached. `upd` pulses even when the held value is unchanged.
- `valid` rises in the same cycle as the first write of `dist_l` and stays high until reset.
- `sel` changes on the cycle GAP exits. It is stable for an entire measurement.
- Cycle period per sensor is `TRIG_CYC` + echo/timeout time + `GAP_CYC` + small fixed overhead.

## Configuration
- `RANGER_TIMEOUT_HOLD_EN` defined:
  - On either timeout, the selected `dist_*` keeps its previous value; `upd` still pulses.
  - A sensor that times out before its first successful measurement stays 0 and still counts toward `valid`.
- `RANGER_TIMEOUT_HOLD_EN` undefined: on either timeout, the selected `dist_*` is written to 255 ("path clear").

## Test plan
Bench parameters: `TRIG_CYC`=3, `CM_CYC`=4, `RISE_TO`=20, `ECHO_TO`=1100, `GAP_CYC`=5.
- Reset release → `trig_m` high exactly 3 cycles; `trig_r`/`trig_l` stay 0; all `dist_*`=0 and `valid`=0.
- `echo_m` high for 80 cycles → `dist_m`=20 with `upd` pulse 3 cycles after the falling edge. 81 and 83 cycles also give 20 (floor); 84 gives 21.
- Full rotation: m=40, r=12, l=120 cycles → `dist_m`=10, `dist_r`=3, `dist_l`=30. `valid` rises with the `dist_l` write. `sel` goes 0,1,2,0.
- Echo held high 1100 cycles → `dist`=255, saturated with no wrap. Repeat with the macro defined: previous value held, `upd` still pulses.
- No echo rise for 20 cycles after trigger → timeout path taken. The next sensor's trigger comes after `GAP_CYC`.
- `rst` asserted during MEASURE on `sel`=1 → next cycle all `trig_*`=0 and `dist_*`=0. After release, a fresh `trig_m` pulse of 3 cycles.
